// File: rtl/piso_serializer.sv
// piso_serializer
// Parallel-in / serial-out converter with a valid/ready load handshake.
// Each accepted WIDTH-bit word is emitted one bit per clock on ser_out,
// starting the cycle after acceptance. A new word can be accepted on the
// edge that retires the last bit, so words stream back-to-back with no gap.
// Every serial-side output (ser_out, ser_valid, busy, done) comes straight
// from a flop.
//
// Datapath note: at acceptance the first bit goes directly into the
// ser_out flop and the shift register receives the remaining bits, already
// advanced by one position. From then on, each edge moves the next bit
// from the head of the shift register into ser_out. The shift register
// therefore only ever holds the bits still waiting to be sent.

module piso_serializer #(
  parameter int WIDTH     = 4,   // bits per parallel word, 2..32
  parameter int LSB_FIRST = 0    // 0: MSB first, 1: LSB first
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  // Counter wide enough to index every bit position of a word
  localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    cnt_inc;

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;

  logic             ser_out_reg;
  logic             ser_out_next;
  logic             done_reg;
  logic             done_next;
  logic             busy_reg;
  logic             busy_next;

  // Bit that leaves first, and the remaining bits after one shift step,
  // for both the incoming word and the word already in the shift register.
  logic             din_head;
  logic             shift_head;
  logic [WIDTH-1:0] din_tail;
  logic [WIDTH-1:0] shift_tail;

  logic             last_bit;
  logic             accept;

  // ------------------------------------------------------------------
  // Head/tail extraction. The shift direction is fixed at elaboration:
  // MSB-first shifts toward the top, LSB-first shifts toward bit 0.
  // Vacated positions fill with 0 so a drained register is all zeros.
  // ------------------------------------------------------------------
  generate
    if (LSB_FIRST != 0) begin : g_head_lsb
      assign din_head   = din[0];
      assign shift_head = shift_reg[0];
    end else begin : g_head_msb
      assign din_head   = din[WIDTH-1];
      assign shift_head = shift_reg[WIDTH-1];
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tail
      if (LSB_FIRST != 0) begin : g_lsb
        if (gi == WIDTH - 1) begin : g_fill
          assign din_tail[gi]   = 1'b0;
          assign shift_tail[gi] = 1'b0;
        end else begin : g_move
          assign din_tail[gi]   = din[gi+1];
          assign shift_tail[gi] = shift_reg[gi+1];
        end
      end else begin : g_msb
        if (gi == 0) begin : g_fill
          assign din_tail[gi]   = 1'b0;
          assign shift_tail[gi] = 1'b0;
        end else begin : g_move
          assign din_tail[gi]   = din[gi-1];
          assign shift_tail[gi] = shift_reg[gi-1];
        end
      end
    end
  endgenerate

  // ------------------------------------------------------------------
  // Handshake. Ready depends only on registered state, never on inputs,
  // so there is no combinational path from load_valid to load_ready.
  // ------------------------------------------------------------------
  assign last_bit   = (state_reg == SHIFT) && (cnt_reg == CNT_LAST);
  assign load_ready = (state_reg == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;
  assign cnt_inc    = cnt_reg + CW'(1);

  // State register: synchronous reset to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: leave SHIFT only after the last bit when no word follows
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit && !accept) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: next values for the counter, shift register and output flops
  always_comb begin
    cnt_next     = '0;
    shift_next   = '0;
    ser_out_next = 1'b0;
    done_next    = 1'b0;
    busy_next    = (state_next == SHIFT);

    if (accept) begin
      // New word: first bit goes straight out, the rest wait in the register
      cnt_next     = '0;
      shift_next   = din_tail;
      ser_out_next = din_head;
      done_next    = (CNT_LAST == '0);
    end else if ((state_reg == SHIFT) && !last_bit) begin
      // Mid-word: move the next pending bit onto the line
      cnt_next     = cnt_inc;
      shift_next   = shift_tail;
      ser_out_next = shift_head;
      done_next    = (cnt_inc == CNT_LAST);
    end else begin
      // Idle, or word finished with nothing queued: line parks at 0
      cnt_next     = '0;
      shift_next   = '0;
      ser_out_next = 1'b0;
      done_next    = 1'b0;
    end
  end

  // Datapath and output registers: reset clears everything, aborting any word
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg     <= '0;
      shift_reg   <= '0;
      ser_out_reg <= 1'b0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      shift_reg   <= shift_next;
      ser_out_reg <= ser_out_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
    end
  end

  assign ser_out   = ser_out_reg;
  assign ser_valid = busy_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one MSB-first and one LSB-first instance share
// the same stimulus. A queue model holds the bits still owed on the line;
// every cycle both instances are compared against it, and each directed
// scenario ends with hand-computed literal expectations of the bit streams.

module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         load_valid;

  logic m_ready, m_out, m_valid, m_busy, m_done;
  logic l_ready, l_out, l_valid, l_busy, l_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(0)) dut_msb (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (m_ready),
    .ser_out    (m_out),
    .ser_valid  (m_valid),
    .busy       (m_busy),
    .done       (m_done)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1)) dut_lsb (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (l_ready),
    .ser_out    (l_out),
    .ser_valid  (l_valid),
    .busy       (l_busy),
    .done       (l_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: queue of bits still owed on the line ----------
  typedef struct packed {
    logic b;
    logic last;
  } ent_t;

  ent_t qm[$];
  ent_t ql[$];

  always @(posedge clk) begin
    bit rdy;
    if (reset) begin
      qm.delete();
      ql.delete();
    end else begin
      // Ready while nothing, or only the final bit, remains outstanding
      rdy = (qm.size() <= 1);
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (load_valid && rdy) begin
        for (int i = 0; i < W; i++) begin
          qm.push_back('{b: din[W-1-i], last: (i == W-1)});
          ql.push_back('{b: din[i],     last: (i == W-1)});
        end
      end
    end
  end

  // ---------------- stream logs for literal expectations -----------------
  logic [31:0] mlog = '0, mdlog = '0, mrlog = '0, llog = '0, ldlog = '0;
  int          mcnt = 0, lcnt = 0;

  // Per-cycle compare against the model, plus logging of valid bits
  always @(negedge clk) begin
    logic ev, eo, ed, er;
    ev = (qm.size() != 0);
    eo = ev ? qm[0].b : 1'b0;
    ed = ev ? qm[0].last : 1'b0;
    er = (qm.size() <= 1);
    check("msb_ser_valid", {31'b0, m_valid}, {31'b0, ev});
    check("msb_ser_out",   {31'b0, m_out},   {31'b0, eo});
    check("msb_done",      {31'b0, m_done},  {31'b0, ed});
    check("msb_busy",      {31'b0, m_busy},  {31'b0, ev});
    check("msb_ready",     {31'b0, m_ready}, {31'b0, er});

    ev = (ql.size() != 0);
    eo = ev ? ql[0].b : 1'b0;
    ed = ev ? ql[0].last : 1'b0;
    er = (ql.size() <= 1);
    check("lsb_ser_valid", {31'b0, l_valid}, {31'b0, ev});
    check("lsb_ser_out",   {31'b0, l_out},   {31'b0, eo});
    check("lsb_done",      {31'b0, l_done},  {31'b0, ed});
    check("lsb_busy",      {31'b0, l_busy},  {31'b0, ev});
    check("lsb_ready",     {31'b0, l_ready}, {31'b0, er});

    if (m_valid) begin
      mlog  = {mlog[30:0], m_out};
      mdlog = {mdlog[30:0], m_done};
      mrlog = {mrlog[30:0], m_ready};
      mcnt++;
    end
    if (l_valid) begin
      llog  = {llog[30:0], l_out};
      ldlog = {ldlog[30:0], l_done};
      lcnt++;
    end
  end

  // Apply inputs, let one rising edge sample them, then settle past the edge
  task automatic step(input logic rst, input logic lv, input logic [W-1:0] d);
    reset      = rst;
    load_valid = lv;
    din        = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  int mbase, lbase;

  initial begin
    reset      = 1'b1;
    load_valid = 1'b1;
    din        = 4'b1111;

    // Reset held two cycles with a word offered: nothing accepted
    step(1'b1, 1'b1, 4'b1111);
    step(1'b1, 1'b1, 4'b1111);
    check("rst_ser_valid", {31'b0, m_valid}, 32'd0);
    check("rst_ser_out",   {31'b0, m_out},   32'd0);
    check("rst_done",      {31'b0, m_done},  32'd0);
    reset      = 1'b0;
    load_valid = 1'b0;
    #1;
    check("rst_ready_after_release", {31'b0, m_ready}, 32'd1);
    idle(2);
    check("rst_no_bits", mcnt, 0);

    // Single word 1011
    mbase = mcnt; lbase = lcnt;
    step(1'b0, 1'b1, 4'b1011);
    idle(5);
    check("single_msb_count", mcnt - mbase, 4);
    check("single_msb_bits",  mlog & 32'hF, 32'hB);   // 1,0,1,1
    check("single_msb_done",  mdlog & 32'hF, 32'h1);  // done on 4th
    check("single_lsb_bits",  llog & 32'hF, 32'hD);   // 1,1,0,1
    check("single_lsb_done",  ldlog & 32'hF, 32'h1);
    check("single_idle_ready", {31'b0, m_ready}, 32'd1);

    // Back-to-back: 1011 held, 0110 presented in the last-bit cycle
    mbase = mcnt; lbase = lcnt;
    step(1'b0, 1'b1, 4'b1011);
    step(1'b0, 1'b1, 4'b1011);
    step(1'b0, 1'b1, 4'b1011);
    step(1'b0, 1'b1, 4'b1011);
    step(1'b0, 1'b1, 4'b0110);
    idle(6);
    check("b2b_msb_count", mcnt - mbase, 8);
    check("b2b_lsb_count", lcnt - lbase, 8);
    check("b2b_msb_bits",  mlog & 32'hFF, 32'hB6);    // 1011_0110
    check("b2b_msb_done",  mdlog & 32'hFF, 32'h11);   // bits 4 and 8
    check("b2b_lsb_bits",  llog & 32'hFF, 32'hD6);    // 1101_0110

    // Stall: 0000 offered during cnt=1 of word 1100 is ignored
    mbase = mcnt; lbase = lcnt;
    step(1'b0, 1'b1, 4'b1100);
    step(1'b0, 1'b0, 4'b1100);
    step(1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 4'b0000);
    idle(3);
    check("stall_msb_count", mcnt - mbase, 4);
    check("stall_msb_bits",  mlog & 32'hF, 32'hC);    // 1,1,0,0
    check("stall_lsb_bits",  llog & 32'hF, 32'h3);    // 0,0,1,1
    check("stall_ready",     mrlog & 32'hF, 32'h1);   // 0 at cnt 0..2

    // Reset after the second bit of 1010, then word 0101
    mbase = mcnt; lbase = lcnt;
    step(1'b0, 1'b1, 4'b1010);
    step(1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b0, 4'b0000);
    check("abort_ser_valid", {31'b0, m_valid}, 32'd0);
    check("abort_ser_out",   {31'b0, m_out},   32'd0);
    step(1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 4'b0101);
    idle(6);
    check("abort_msb_count", mcnt - mbase, 6);
    check("abort_msb_bits",  mlog & 32'h3F, 32'h25);  // 10 | 0101
    check("abort_msb_done",  mdlog & 32'h3F, 32'h01); // no done for aborted word
    check("abort_lsb_bits",  llog & 32'h3F, 32'h1A);  // 01 | 1010
    check("abort_lsb_done",  ldlog & 32'h3F, 32'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

endmodule
